dac_data_format: RTL and testbench

- Transmit-side counterpart of the ADC input formatter: takes signed two's-complement samples from the DSP core and drives a 13-bit offset-binary DAC bus.
- Stages: saturate, convert to offset binary, programmable 0–31 cycle alignment delay, then an IOB-packed output register.
- Sits between the feedback/DSP output and the DAC LVDS pins. It is used to time-align the DAC with the ADC path.

---
 rtl/dac_data_format_pkg.sv | 37 +++
 rtl/dac_data_format_if.sv | 19 +
 rtl/dac_data_format_delay_line.sv | 49 ++++
 rtl/dac_data_format.sv | 147 ++++++++++++++
 tb/tb_dac_data_format.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_data_format_pkg.sv
// dac_data_format_pkg
//   Constants and helpers shared by the DAC output formatter and its
//   ADC-side counterpart: DAC code width, the offset-binary midscale/sign-flip
//   constant, signed saturation limits and the alignment-tap width.
package dac_data_format_pkg;

  localparam int unsigned DAC_W = 13;
  localparam int unsigned TAP_W = 5;

  // Offset-binary code for signed zero; XOR with it flips the sign bit.
  localparam logic [DAC_W-1:0] DAC_MIDSCALE = 13'h1000;
  localparam logic [DAC_W-1:0] BITFLIP      = DAC_MIDSCALE;

  localparam int SAT_MAX = 4095;
  localparam int SAT_MIN = -4096;

  typedef struct packed {
    logic             hit;
    logic [DAC_W-1:0] val;
  } sat_t;

  // Clamp a signed value into the 13-bit two's-complement range.
  function automatic sat_t sat13(input int v);
    sat_t r;
    r.hit = 1'b0;
    r.val = DAC_W'(v);
    if (v > SAT_MAX) begin
      r.hit = 1'b1;
      r.val = DAC_W'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      r.hit = 1'b1;
      r.val = DAC_W'(SAT_MIN);
    end
    return r;
  endfunction

endpackage

// File: rtl/dac_data_format_if.sv
// dac_data_format_if
//   Sample bus between the DSP core and the DAC formatter.
//   din/din_valid : signed sample from the DSP core and its qualifier
//   dout/dout_valid : offset-binary DAC code and real-sample flag
//   master = DSP/bench side, slave = formatter side.
interface dac_data_format_if #(
  parameter int unsigned DIN_W = 15
);
  import dac_data_format_pkg::*;

  logic signed [DIN_W-1:0] din;
  logic                    din_valid;
  logic [DAC_W-1:0]        dout;
  logic                    dout_valid;

  modport master (output din, din_valid, input dout, dout_valid);
  modport slave  (input din, din_valid, output dout, dout_valid);

endinterface

// File: rtl/dac_data_format_delay_line.sv
// dac_delay_line
//   Circular-buffer delay of 0..DEPTH-1 cycles for alignment paths.
//   clk, rst_n : clock, async active-low reset (write pointer only)
//   din        : word written every cycle
//   tap        : delay in cycles; 0 passes din straight through
//   dout       : word written tap cycles ago (combinational read)
//   The storage array is not reset; callers must mask its output until it
//   has been filled.
module dac_delay_line #(
  parameter  int unsigned W     = 14,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  din,
  input  logic [AW-1:0] tap,
  output logic [W-1:0]  dout
);

  logic [W-1:0]  ram [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW:0]   back;

  always_ff @(posedge clk) begin
    ram[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (wptr == AW'(DEPTH - 1)) begin
      wptr <= '0;
    end else begin
      wptr <= wptr + AW'(1);
    end
  end

  // (wptr - tap) mod DEPTH, valid for non-power-of-two depths as well.
  always_comb begin
    back = {1'b0, wptr} + (AW+1)'(DEPTH) - {1'b0, tap};
    if (back >= (AW+1)'(DEPTH)) begin
      back = back - (AW+1)'(DEPTH);
    end
  end

  assign dout = (tap == '0) ? din : ram[back[AW-1:0]];

endmodule

// File: rtl/dac_data_format.sv
// dac_data_format
//   Formats signed DSP samples for a 13-bit offset-binary DAC: saturate,
//   sign-flip to offset binary, programmable 0..DEPTH-1 cycle alignment delay,
//   then the output register.
//   clk, rst_n  : sample clock, async active-low reset
//   bus (slave) : din/din_valid in, dout/dout_valid out
//   sr_bypass   : 1 = skip delay line (latency 2)
//   sr_tap      : alignment delay when sr_bypass = 0 (latency 2 + sr_tap)
//   sat_clr     : synchronous clear of sat_flag (saturation wins)
//   test_mode   : selects ramp pattern, only when TEST_PATTERN_EN is defined
//   sat_flag    : sticky saturation indicator
//   Optional feature macro: TEST_PATTERN_EN (13-bit ramp source).
module dac_data_format
  import dac_data_format_pkg::*;
#(
  parameter int unsigned      DIN_W    = 15,
  parameter int unsigned      DEPTH    = 32,
  parameter logic [DAC_W-1:0] MIDSCALE = DAC_MIDSCALE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dac_data_format_if.slave     bus,
  input  logic                 sr_bypass,
  input  logic [TAP_W-1:0]     sr_tap,
  input  logic                 sat_clr,
  input  logic                 test_mode,
  output logic                 sat_flag
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic signed [DIN_W-1:0] din_s;
  int                      src;
  sat_t                    sat_r;
  logic [DAC_W-1:0]        s1_d, s1;
  logic                    v1_d, v1, sat_hit;

  assign din_s = bus.din;

`ifdef TEST_PATTERN_EN
  logic [DAC_W-1:0] ramp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
    end else begin
      ramp <= ramp + DAC_W'(1);
    end
  end
`else
  logic test_mode_unused;
  assign test_mode_unused = test_mode;
`endif

  // Stage 1: zero-stuff, saturate, convert to offset binary.
  always_comb begin
    src     = bus.din_valid ? {{(32-DIN_W){din_s[DIN_W-1]}}, din_s} : 0;
    sat_r   = sat13(src);
    s1_d    = sat_r.val ^ BITFLIP;
    v1_d    = bus.din_valid;
    sat_hit = sat_r.hit;
`ifdef TEST_PATTERN_EN
    if (test_mode) begin
      s1_d    = ramp ^ BITFLIP;
      v1_d    = 1'b1;
      sat_hit = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= MIDSCALE;
      v1       <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      s1 <= s1_d;
      v1 <= v1_d;
      if (sat_hit) begin
        sat_flag <= 1'b1;
      end else if (sat_clr) begin
        sat_flag <= 1'b0;
      end
    end
  end

  // The delay path runs on registered tap/bypass so the cycle that detects a
  // change still uses the old setting; the first cycle after reset only
  // primes the registers, so reset blanking stays DEPTH-1 cycles.
  logic [TAP_W-1:0] tap_q;
  logic             byp_q, primed, cfg_change;
  logic [AW-1:0]    blank_cnt;

  assign cfg_change = primed && ((sr_tap != tap_q) || (sr_bypass != byp_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q     <= '0;
      byp_q     <= 1'b0;
      primed    <= 1'b0;
      blank_cnt <= AW'(DEPTH - 1);
    end else begin
      tap_q  <= sr_tap;
      byp_q  <= sr_bypass;
      primed <= 1'b1;
      if (cfg_change) begin
        blank_cnt <= AW'(DEPTH - 1);
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - AW'(1);
      end
    end
  end

  logic [DAC_W:0] dl_q;

  dac_delay_line #(
    .W     (DAC_W + 1),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({v1, s1}),
    .tap   (AW'(tap_q)),
    .dout  (dl_q)
  );

  logic [DAC_W-1:0] dout_r;
  logic             dout_valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r       <= MIDSCALE;
      dout_valid_r <= 1'b0;
    end else if (blank_cnt != '0) begin
      dout_r       <= MIDSCALE;
      dout_valid_r <= 1'b0;
    end else if (byp_q) begin
      {dout_valid_r, dout_r} <= {v1, s1};
    end else begin
      {dout_valid_r, dout_r} <= dl_q;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;

endmodule

// File: tb/tb_dac_data_format.sv
// tb_dac_data_format
//   Self-checking bench for dac_data_format. A recorder logs the inputs seen
//   at every rising edge since reset release; expected outputs are derived
//   from that history with the formatter's arithmetic rules (clamp, sign
//   flip, latency 2 + tap, DEPTH-1 blanking after reset or a setting change).
module tb_dac_data_format;

  localparam int DIN_W = 15;
  localparam int DEPTH = 32;
  localparam int BLANK = DEPTH - 1;
  localparam int HN    = 16384;
  localparam logic [13:0] BLANKED = {1'b0, 13'h1000};

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       sr_bypass = 1'b1;
  logic [4:0] sr_tap    = 5'd0;
  logic       sat_clr   = 1'b0;
  logic       test_mode = 1'b0;
  logic       sat_flag;

  int checks = 0;
  int errors = 0;

  dac_data_format_if #(.DIN_W(DIN_W)) bus ();

  dac_data_format #(
    .DIN_W    (DIN_W),
    .DEPTH    (DEPTH),
    .MIDSCALE (13'h1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sr_bypass (sr_bypass),
    .sr_tap    (sr_tap),
    .sat_clr   (sat_clr),
    .test_mode (test_mode),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  // ---------------- input history + reference model ----------------
  int cyc = 0;
  int h_din [HN];
  bit h_v   [HN];
  bit h_byp [HN];
  int h_tap [HN];
`ifdef TEST_PATTERN_EN
  bit h_tm  [HN];
`endif
  bit m_sat = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc   = 0;
      m_sat = 1'b0;
    end else begin
      bit ev;
      cyc = cyc + 1;
      if (cyc < HN) begin
        h_din[cyc] = int'(bus.din);
        h_v[cyc]   = bus.din_valid;
        h_byp[cyc] = sr_bypass;
        h_tap[cyc] = int'(sr_tap);
`ifdef TEST_PATTERN_EN
        h_tm[cyc]  = test_mode;
`endif
      end
      ev = bus.din_valid && (int'(bus.din) > 4095 || int'(bus.din) < -4096);
`ifdef TEST_PATTERN_EN
      if (test_mode) ev = 1'b0;
`endif
      if (ev) m_sat = 1'b1;
      else if (sat_clr) m_sat = 1'b0;
    end
  end

  // {valid, code} of the sample captured at edge m.
  function automatic logic [13:0] sample_at(int m);
    int s;
    if (m < 1) return BLANKED;
`ifdef TEST_PATTERN_EN
    if (h_tm[m]) return {1'b1, 13'((m - 1) % 8192) ^ 13'h1000};
`endif
    s = h_v[m] ? h_din[m] : 0;
    if (s > 4095) s = 4095;
    else if (s < -4096) s = -4096;
    return {h_v[m], 13'(s) ^ 13'h1000};
  endfunction

  // {dout_valid, dout} expected just after edge n.
  function automatic logic [13:0] exp_out(int n);
    if (n <= BLANK) return BLANKED;
    for (int c = n - BLANK; c <= n - 1; c++)
      if (c >= 2 && (h_tap[c] != h_tap[c-1] || h_byp[c] != h_byp[c-1]))
        return BLANKED;
    if (h_byp[n-1]) return sample_at(n - 1);
    return sample_at(n - 1 - h_tap[n-1]);
  endfunction

  function automatic logic signed [DIN_W-1:0] rnd_inrange();
    return DIN_W'(int'($urandom_range(0, 7999)) - 4000);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sr_bypass = 1'b1; sr_tap = 5'd0; sat_clr = 1'b0; test_mode = 1'b0;
    bus.din = DIN_W'(1234); bus.din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.dout !== 13'h1000) begin
      errors++; $display("FAIL reset_dout got=%h exp=1000", bus.dout);
    end
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid);
    end
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++; $display("FAIL reset_sat got=%b exp=0", sat_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= BLANK; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.dout_valid, bus.dout} !== BLANKED) begin
        errors++;
        $display("FAIL reset_blank cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, BLANKED);
      end
    end
  endtask

  task automatic test_saturation();
    int          vals [5];
    logic [12:0] codes [5];
    logic [13:0] e;
    vals  = '{0, 100, -1, 5000, -9000};
    codes = '{13'h1000, 13'h1064, 13'h0FFF, 13'h1FFF, 13'h0000};
    for (int i = 0; i < 8; i++) begin
      bus.din_valid = 1'b1;
      if (i < 5) bus.din = DIN_W'(vals[i]);
      else       bus.din = '0;
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL sat_model cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
      if (i >= 1 && i <= 5) begin
        checks++;
        if (bus.dout !== codes[i-1]) begin
          errors++; $display("FAIL sat_code i=%0d got=%h exp=%h", i, bus.dout, codes[i-1]);
        end
      end
      checks++;
      if (sat_flag !== (i >= 3)) begin
        errors++; $display("FAIL sat_flag i=%0d got=%b exp=%b", i, sat_flag, (i >= 3));
      end
    end
  endtask

  task automatic test_delay_timing();
    logic [13:0] e;
    logic [12:0] ex;
    sr_bypass = 1'b0; sr_tap = 5'd7;
    bus.din_valid = 1'b1; bus.din = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL delay_settle cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
    end
    for (int j = 0; j < 16; j++) begin
      bus.din = (j == 0) ? DIN_W'(1000) : '0;
      @(posedge clk); #1;
      e  = exp_out(cyc);
      ex = (j == 8) ? 13'h13E8 : 13'h1000;
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL delay_model cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
      checks++;
      if (bus.dout !== ex) begin
        errors++; $display("FAIL delay_impulse j=%0d got=%h exp=%h", j, bus.dout, ex);
      end
    end
  endtask

  task automatic test_tap_change();
    logic [13:0] e;
    sr_tap = 5'd31;
    bus.din_valid = 1'b1;
    for (int j = 0; j < 52; j++) begin
      bus.din = rnd_inrange();
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL tap_model cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
      checks++;
      if (j >= 1 && j <= BLANK) begin
        if ({bus.dout_valid, bus.dout} !== BLANKED) begin
          errors++; $display("FAIL tap_blank j=%0d got=%h exp=%h", j, {bus.dout_valid, bus.dout}, BLANKED);
        end
      end else if (bus.dout_valid !== 1'b1) begin
        errors++; $display("FAIL tap_valid j=%0d got=%b exp=1", j, bus.dout_valid);
      end
    end
  endtask

  task automatic test_zero_stuff();
    logic [13:0] e;
    logic [13:0] ex [3];
    ex = '{{1'b1, 13'h17D0}, {1'b0, 13'h1000}, {1'b1, 13'h17D0}};
    for (int j = 0; j < 40; j++) begin
      if (j < 3) begin
        bus.din = DIN_W'(2000); bus.din_valid = (j != 1);
      end else begin
        bus.din = '0; bus.din_valid = 1'b1;
      end
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL zs_model cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
      if (j >= 32 && j <= 34) begin
        checks++;
        if ({bus.dout_valid, bus.dout} !== ex[j-32]) begin
          errors++; $display("FAIL zs_out j=%0d got=%h exp=%h", j, {bus.dout_valid, bus.dout}, ex[j-32]);
        end
      end
    end
  endtask

  task automatic test_sat_priority();
    bus.din_valid = 1'b1; bus.din = DIN_W'(5000); sat_clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sat_flag !== 1'b1) begin
      errors++; $display("FAIL satpri_set got=%b exp=1", sat_flag);
    end
    bus.din = '0;
    @(posedge clk); #1;
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++; $display("FAIL satpri_clr got=%b exp=0", sat_flag);
    end
    sat_clr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++; $display("FAIL satpri_hold got=%b exp=0", sat_flag);
    end
  endtask

  task automatic test_random();
    logic [13:0] e;
    for (int i = 0; i < 800; i++) begin
      bus.din_valid = ($urandom_range(0, 3) != 0);
      bus.din = ($urandom_range(0, 4) == 0) ? DIN_W'($urandom) : rnd_inrange();
      sat_clr   = ($urandom_range(0, 7) == 0);
      test_mode = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) begin
        sr_tap    = 5'($urandom);
        sr_bypass = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
      checks++;
      if (sat_flag !== m_sat) begin
        errors++; $display("FAIL rnd_sat cyc=%0d got=%b exp=%b", cyc, sat_flag, m_sat);
      end
    end
    sat_clr = 1'b0; test_mode = 1'b0;
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    logic [13:0] e;
    logic [12:0] prev;
    bit          wrap_seen;
    wrap_seen = 1'b0;
    test_mode = 1'b0; bus.din_valid = 1'b0; sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++; $display("FAIL pat_preclr got=%b exp=0", sat_flag);
    end
    test_mode = 1'b1; sr_bypass = 1'b1; bus.din_valid = 1'b1;
    for (int j = 0; j < BLANK + 3; j++) begin
      bus.din = DIN_W'($urandom);
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL pat_settle cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
    end
    prev = bus.dout;
    for (int j = 0; j < 8300; j++) begin
      bus.din = DIN_W'($urandom);
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL pat_model cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
      checks++;
      if ({bus.dout_valid, bus.dout} !== {1'b1, 13'(prev + 13'd1)}) begin
        errors++; $display("FAIL pat_step cyc=%0d got=%h prev=%h", cyc, {bus.dout_valid, bus.dout}, prev);
      end
      if (prev == 13'h1FFF && bus.dout == 13'h0000) wrap_seen = 1'b1;
      checks++;
      if (sat_flag !== 1'b0) begin
        errors++; $display("FAIL pat_sat cyc=%0d got=%b exp=0", cyc, sat_flag);
      end
      prev = bus.dout;
    end
    checks++;
    if (!wrap_seen) begin
      errors++; $display("FAIL pat_wrap got=none exp=1FFF->0000");
    end
    test_mode = 1'b0;
  endtask
`endif

  task automatic test_reset_midstream();
    logic [13:0] e;
    sr_bypass = 1'b1; bus.din_valid = 1'b1;
    for (int j = 0; j < BLANK + 8; j++) begin
      bus.din = rnd_inrange();
      @(posedge clk); #1;
    end
    checks++;
    if (bus.dout_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got=%b exp=1", bus.dout_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dout_valid, bus.dout} !== BLANKED) begin
      errors++; $display("FAIL mid_async got=%h exp=%h", {bus.dout_valid, bus.dout}, BLANKED);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < BLANK + 10; j++) begin
      bus.din = rnd_inrange();
      @(posedge clk); #1;
      e = exp_out(cyc);
      checks++;
      if ({bus.dout_valid, bus.dout} !== e) begin
        errors++; $display("FAIL mid_after cyc=%0d got=%h exp=%h", cyc, {bus.dout_valid, bus.dout}, e);
      end
    end
  endtask

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    test_reset();
    test_saturation();
    test_delay_timing();
    test_tap_change();
    test_zero_stuff();
    test_sat_priority();
    test_random();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
